// File: rtl/stream_operand_mux.sv
// stream_operand_mux: NUM_IN-way valid/ready operand selector with one
// registered output stage, direct-select or round-robin arbitration.
//
// Ports:
//   clk, rst     - rising-edge clock, synchronous active-high reset
//   in_data      - NUM_IN packed channels, channel i at [i*WIDTH +: WIDTH]
//   in_valid     - per-channel valid
//   in_ready     - per-channel ready, combinational, one-hot or zero
//   mode         - 0 = direct select by sel, 1 = round-robin
//   sel          - channel index used in direct mode
//   out_data     - registered selected beat
//   out_src      - channel index that supplied out_data
//   out_valid    - output stage holds an unconsumed beat
//   out_ready    - downstream accepts the beat
//   xfer_count   - accepted input beats, wraps modulo 2^CNT_W
module stream_operand_mux #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        xfer_count
);

    logic [WIDTH-1:0] chan [NUM_IN];
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] grant;
    logic [SEL_W-1:0] next_ptr;
    logic             has_grant;
    logic             load;
    logic             xfer;
    int               idx;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_chan
        assign chan[g] = in_data[g*WIDTH +: WIDTH];
    end

    // The output register may take a new beat whenever it is empty or
    // being drained this cycle, so a steady stream sees no bubbles.
    assign load = !out_valid || out_ready;

    always_comb begin
        has_grant = 1'b0;
        grant     = '0;
        idx       = 0;
        if (!mode) begin
            grant     = sel;
            has_grant = int'(sel) < NUM_IN;
        end else begin
            // Search starts at rr_ptr and wraps; first valid channel wins.
            for (int k = 0; k < NUM_IN; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_IN) begin
                    idx = idx - NUM_IN;
                end
                if (!has_grant && in_valid[idx]) begin
                    has_grant = 1'b1;
                    grant     = SEL_W'(idx);
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            in_ready[i] = load && has_grant && (grant == SEL_W'(i));
        end
    end

    assign xfer = load && has_grant && in_valid[grant];

    assign next_ptr = (int'(grant) == NUM_IN - 1) ? '0 : grant + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data   <= '0;
            out_src    <= '0;
            out_valid  <= 1'b0;
            xfer_count <= '0;
            rr_ptr     <= '0;
        end else if (xfer) begin
            out_data   <= chan[grant];
            out_src    <= grant;
            out_valid  <= 1'b1;
            xfer_count <= xfer_count + 1'b1;
            if (mode) begin
                rr_ptr <= next_ptr;
            end
        end else if (load) begin
            // Drained with nothing to replace it; data/src keep last beat.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_operand_mux.sv
// tb_stream_operand_mux: directed scenario tasks for stream_operand_mux.
// Counter is built with CNT_W=4 so wrap-around is reachable quickly.
module tb_stream_operand_mux;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  xfer_count;
    logic [7:0]  ch [4];

    int passed;
    int total;

    assign in_data = {ch[3], ch[2], ch[1], ch[0]};

    stream_operand_mux #(
        .WIDTH(8), .NUM_IN(4), .SEL_W(2), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sel(sel),
        .out_data(out_data), .out_src(out_src),
        .out_valid(out_valid), .out_ready(out_ready),
        .xfer_count(xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are sampled there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid);
        else passed++;
        total++;
        if (out_data !== 8'h00) $display("FAIL reset_data got %h want 00", out_data);
        else passed++;
        total++;
        if (out_src !== 2'd0) $display("FAIL reset_src got %0d want 0", out_src);
        else passed++;
        total++;
        if (xfer_count !== 4'd0) $display("FAIL reset_cnt got %0d want 0", xfer_count);
        else passed++;
    endtask

    task automatic test_direct();
        ch[0] = 8'h11; ch[1] = 8'h22; ch[2] = 8'hA5; ch[3] = 8'h44;
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0100) $display("FAIL direct_ready got %b want 0100", in_ready);
        else passed++;
        tick();
        total++;
        if (out_data !== 8'hA5 || out_src !== 2'd2 || out_valid !== 1'b1)
            $display("FAIL direct_out got %h/%0d/%b want a5/2/1", out_data, out_src, out_valid);
        else passed++;
        total++;
        if (xfer_count !== 4'd1) $display("FAIL direct_cnt1 got %0d want 1", xfer_count);
        else passed++;
        tick();
        total++;
        if (xfer_count !== 4'd2) $display("FAIL direct_cnt2 got %0d want 2", xfer_count);
        else passed++;
        // Ready in direct mode ignores the channel's own valid.
        in_valid = 4'b0000;
        #1;
        total++;
        if (in_ready !== 4'b0100) $display("FAIL direct_ready_novalid got %b want 0100", in_ready);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0 || out_data !== 8'hA5 || xfer_count !== 4'd2)
            $display("FAIL direct_drain got %b/%h/%0d want 0/a5/2", out_valid, out_data, xfer_count);
        else passed++;
    endtask

    task automatic test_backpressure();
        mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b1;
        ch[1] = 8'h10;
        tick();
        total++;
        if (out_data !== 8'h10 || out_valid !== 1'b1)
            $display("FAIL bp_first got %h/%b want 10/1", out_data, out_valid);
        else passed++;
        ch[1] = 8'h11;
        tick();
        out_ready = 1'b0;
        ch[1] = 8'h12;
        sel = 2'd3;
        #1;
        total++;
        if (in_ready !== 4'b0000) $display("FAIL bp_ready_low got %b want 0000", in_ready);
        else passed++;
        sel = 2'd1;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (out_data !== 8'h11 || out_valid !== 1'b1 || out_src !== 2'd1 || in_ready !== 4'b0000)
                $display("FAIL bp_hold%0d got %h/%b/%0d/%b want 11/1/1/0000",
                         c, out_data, out_valid, out_src, in_ready);
            else passed++;
        end
        total++;
        if (xfer_count !== 4'd4) $display("FAIL bp_cnt_hold got %0d want 4", xfer_count);
        else passed++;
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0010) $display("FAIL bp_release_ready got %b want 0010", in_ready);
        else passed++;
        tick();
        in_valid = 4'b0000;
        total++;
        if (out_data !== 8'h12 || out_valid !== 1'b1 || xfer_count !== 4'd5)
            $display("FAIL bp_release got %h/%b/%0d want 12/1/5", out_data, out_valid, xfer_count);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0 || xfer_count !== 4'd5)
            $display("FAIL bp_nodup got %b/%0d want 0/5", out_valid, xfer_count);
        else passed++;
    endtask

    task automatic test_rr_rotation();
        logic [1:0] exp_all [5];
        logic [1:0] exp_odd [4];
        exp_all = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_odd = '{2'd1, 2'd3, 2'd1, 2'd3};
        ch[0] = 8'hC0; ch[1] = 8'hC1; ch[2] = 8'hC2; ch[3] = 8'hC3;
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
            total++;
            if (out_src !== exp_all[n] || out_data !== {6'h30, exp_all[n]} || out_valid !== 1'b1)
                $display("FAIL rr_all%0d got %0d/%h want %0d/%h",
                         n, out_src, out_data, exp_all[n], {6'h30, exp_all[n]});
            else passed++;
        end
        in_valid = 4'b1010;
        for (int n = 0; n < 4; n++) begin
            tick();
            total++;
            if (out_src !== exp_odd[n] || out_valid !== 1'b1)
                $display("FAIL rr_odd%0d got %0d want %0d", n, out_src, exp_odd[n]);
            else passed++;
        end
    endtask

    task automatic test_rr_wrap();
        // Pointer is 0 here; a lone ch2 grant moves it to 3.
        mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0100;
        tick();
        in_valid = 4'b0001;
        #1;
        total++;
        if (in_ready !== 4'b0001) $display("FAIL wrap_ready got %b want 0001", in_ready);
        else passed++;
        tick();
        total++;
        if (out_src !== 2'd0 || out_data !== 8'hC0)
            $display("FAIL wrap_grant got %0d/%h want 0/c0", out_src, out_data);
        else passed++;
        in_valid = 4'b1111;
        #1;
        total++;
        if (in_ready !== 4'b0010) $display("FAIL wrap_ptr1 got %b want 0010", in_ready);
        else passed++;
        in_valid = 4'b0000;
        #1;
        total++;
        if (in_ready !== 4'b0000) $display("FAIL rr_none_ready got %b want 0000", in_ready);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0 || out_src !== 2'd0)
            $display("FAIL rr_none_drain got %b/%0d want 0/0", out_valid, out_src);
        else passed++;
    endtask

    task automatic test_counter_wrap();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b1;
        for (int n = 0; n < 16; n++) tick();
        total++;
        if (xfer_count !== 4'd0) $display("FAIL cnt_wrap16 got %0d want 0", xfer_count);
        else passed++;
        tick();
        total++;
        if (xfer_count !== 4'd1) $display("FAIL cnt_wrap17 got %0d want 1", xfer_count);
        else passed++;
    endtask

    task automatic test_reset_mid();
        // Put the pointer away from 0 so reset must clear it.
        mode = 1'b1; in_valid = 4'b0100; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b1) $display("FAIL mid_setup got %b want 1", out_valid);
        else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0 || xfer_count !== 4'd0 || out_data !== 8'h00)
            $display("FAIL mid_reset got %b/%0d/%h want 0/0/00", out_valid, xfer_count, out_data);
        else passed++;
        in_valid = 4'b1111; out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0001) $display("FAIL mid_first_ready got %b want 0001", in_ready);
        else passed++;
        tick();
        total++;
        if (out_src !== 2'd0 || out_valid !== 1'b1)
            $display("FAIL mid_first_grant got %0d/%b want 0/1", out_src, out_valid);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total = 0;
        rst = 1'b0; mode = 1'b0; sel = 2'd0; in_valid = 4'b0000; out_ready = 1'b0;
        ch[0] = 8'h00; ch[1] = 8'h00; ch[2] = 8'h00; ch[3] = 8'h00;
        tick();
        test_reset();
        test_direct();
        test_backpressure();
        test_rr_rotation();
        test_rr_wrap();
        test_counter_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
